pio_cmd_bridge: RTL and testbench

PIO_CMD_BRIDGE -- requirements
Module: pio_cmd_bridge

---
 rtl/pio_cmd_bridge.sv | 177 +++++++++++++++++
 tb/tb_pio_cmd_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_bridge.sv
// rtl/pio_cmd_bridge.sv - host byte-frame to PIO command bridge with PULL read-back
// Optional partial-frame timeout is enabled by defining PIO_CMD_TIMEOUT_EN.
module pio_cmd_bridge #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  output logic [4:0]  index,
  output logic [31:0] din,
  input  logic [31:0] dout,
  output logic [7:0]  err_count
);

  localparam logic [3:0] ACT_PULL = 4'd3;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    IDX   = 3'd1,
    DATA  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_cnt;
  logic [1:0]  next_cnt;
  logic [3:0]  hdr_action;
  logic [31:0] resp;
  logic        rx_fire;
  logic        tx_fire;
  logic        last_byte;
  logic        act_ok;
  logic        act_bad;
  logic        frame_done;
  logic        timeout_hit;
  logic        err_inc;

  assign rx_fire    = rx_valid & rx_ready;
  assign tx_fire    = tx_valid & tx_ready;
  assign last_byte  = (byte_cnt == 2'd3);
  assign next_cnt   = byte_cnt + 2'd1;
  assign act_ok     = (hdr_action != 4'd0) && (hdr_action < 4'd13);
  assign act_bad    = (hdr_action >= 4'd13);
  assign frame_done = (state == DATA) && rx_fire && last_byte;

`ifdef PIO_CMD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;
  logic          in_frame;

  assign in_frame    = (state == IDX) || (state == DATA);
  assign timeout_hit = in_frame && !rx_fire && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (in_frame && !rx_fire && !timeout_hit) begin
      idle_cnt <= idle_cnt + TW'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  // No timeout logic in this build; the parameter only keeps the interface uniform.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HDR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_inc    = 1'b0;
    case (state)
      HDR:   if (rx_fire) state_next = IDX;
      IDX: begin
        if (timeout_hit) begin
          state_next = HDR;
          err_inc    = 1'b1;
        end else if (rx_fire) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (timeout_hit) begin
          state_next = HDR;
          err_inc    = 1'b1;
        end else if (frame_done) begin
          // Unissuable frames are swallowed here and never reach ISSUE.
          state_next = act_ok ? ISSUE : HDR;
          err_inc    = act_bad;
        end
      end
      ISSUE: state_next = (action == ACT_PULL) ? WAIT : HDR;
      WAIT:  state_next = RESP;
      RESP:  if (tx_fire && last_byte) state_next = HDR;
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready   <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'd0;
      action     <= 4'd0;
      mindex     <= 2'd0;
      index      <= 5'd0;
      din        <= 32'd0;
      err_count  <= 8'd0;
      byte_cnt   <= 2'd0;
      hdr_action <= 4'd0;
      resp       <= 32'd0;
    end else begin
      rx_ready <= (state_next == HDR) || (state_next == IDX) || (state_next == DATA);
      action   <= (frame_done && act_ok) ? hdr_action : 4'd0;

      if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      case (state)
        HDR: begin
          if (rx_fire) begin
            hdr_action <= rx_data[3:0];
            mindex     <= rx_data[5:4];
            byte_cnt   <= 2'd0;
          end
        end
        IDX: begin
          if (rx_fire) index <= rx_data[4:0];
        end
        DATA: begin
          if (rx_fire) begin
            din[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt                     <= next_cnt;
          end
        end
        WAIT: begin
          resp     <= dout;
          tx_data  <= dout[7:0];
          tx_valid <= 1'b1;
          byte_cnt <= 2'd0;
        end
        RESP: begin
          if (tx_fire) begin
            byte_cnt <= next_cnt;
            if (last_byte) begin
              tx_valid <= 1'b0;
            end else begin
              tx_data <= resp[{next_cnt, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_bridge.sv
// tb/tb_pio_cmd_bridge.sv - scoreboard bench for pio_cmd_bridge
// Covers the PIO_CMD_TIMEOUT_EN build (TIMEOUT_CYCLES=16) when that macro is defined.
module tb_pio_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [3:0]  action;
  logic [1:0]  mindex;
  logic [4:0]  index;
  logic [31:0] din;
  logic [31:0] dout = 32'd0;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [42:0] strobe_exp[$];
  logic [42:0] strobe_obs[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  tx_obs[$];
  logic [31:0] pull_val = 32'd0;
  logic        pull_seen = 1'b0;

  pio_cmd_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .action(action), .mindex(mindex), .index(index), .din(din),
    .dout(dout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // PIO model: read data is valid in the cycle after the PULL strobe, garbage otherwise.
  always @(posedge clk) begin
    pull_seen = (action == 4'd3);
    #1;
    dout = pull_seen ? pull_val : 32'h0BAD_F00D;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (action != 4'd0) strobe_obs.push_back({action, mindex, index, din});
      if (tx_valid && tx_ready) tx_obs.push_back(tx_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic clear_q();
    strobe_exp.delete();
    strobe_obs.delete();
    tx_exp.delete();
    tx_obs.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_ready: rx_ready=%b required 1 within 50 cycles", rx_ready);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [31:0] d);
    send_byte(b0);
    send_byte(b1);
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL reset_rx_ready: got %b required 0", rx_ready);
    end
    checks++;
    if ({action, mindex, index, din} !== 43'd0) begin
      errors++; $display("FAIL reset_cmd: got %h required 0", {action, mindex, index, din});
    end
    checks++;
    if ({tx_valid, tx_data, err_count} !== 17'd0) begin
      errors++; $display("FAIL reset_tx_err: got %h required 0", {tx_valid, tx_data, err_count});
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b required 1", rx_ready);
    end
  endtask

  task automatic test_write();
    clear_q();
    strobe_exp.push_back({4'd1, 2'd0, 5'd5, 32'h0000_1234});
    send_frame(8'h01, 8'h05, 32'h0000_1234);
    checks++;
    if ({action, mindex, index, din} !== {4'd1, 2'd0, 5'd5, 32'h0000_1234}) begin
      errors++; $display("FAIL write_latency: got %h required %h", {action, mindex, index, din}, {4'd1, 2'd0, 5'd5, 32'h0000_1234});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({action, rx_ready, index, din} !== {4'd0, 1'b1, 5'd5, 32'h0000_1234}) begin
      errors++; $display("FAIL write_hold: got %h required %h", {action, rx_ready, index, din}, {4'd0, 1'b1, 5'd5, 32'h0000_1234});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobe_obs.size() != strobe_exp.size() || tx_obs.size() != 0) begin
      errors++; $display("FAIL write_count: got %0d strobes %0d tx, required %0d strobes 0 tx", strobe_obs.size(), tx_obs.size(), strobe_exp.size());
    end else begin
      foreach (strobe_exp[k]) begin
        checks++;
        if (strobe_obs[k] !== strobe_exp[k]) begin
          errors++; $display("FAIL write_strobe: got %h required %h", strobe_obs[k], strobe_exp[k]);
        end
      end
    end
  endtask

  task automatic test_pull(input logic stall);
    int n;
    int rr_bad;
    int hold_bad;
    clear_q();
    pull_val = 32'hDEAD_BEEF;
    tx_ready = !stall;
    strobe_exp.push_back({4'd3, 2'd1, 5'd0, 32'd0});
    tx_exp.push_back(8'hEF); tx_exp.push_back(8'hBE);
    tx_exp.push_back(8'hAD); tx_exp.push_back(8'hDE);
    send_frame(8'h13, 8'h00, 32'd0);
    checks++;
    if ({action, mindex} !== {4'd3, 2'd1}) begin
      errors++; $display("FAIL pull_strobe: got action=%0d mindex=%0d required 3/1", action, mindex);
    end
    if (stall) begin
      n = 0;
      while (tx_valid !== 1'b1 && n < 10) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (tx_valid !== 1'b1) begin
        errors++; $display("FAIL stall_valid: tx_valid=%b required 1", tx_valid);
      end
      hold_bad = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEF || rx_ready !== 1'b0) hold_bad++;
      end
      checks++;
      if (hold_bad != 0) begin
        errors++; $display("FAIL stall_hold: %0d unstable cycles, required 0 (tx_data=%h)", hold_bad, tx_data);
      end
      tx_ready = 1'b1;
    end
    n = 0;
    rr_bad = 0;
    while (tx_obs.size() < 4 && n < 40) begin
      @(posedge clk); #1; n++;
      if (tx_obs.size() < 4 && rx_ready !== 1'b0) rr_bad++;
    end
    checks++;
    if (tx_obs.size() != 4 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || rr_bad != 0) begin
      errors++; $display("FAIL pull_resp_end: bytes=%0d rx_ready=%b tx_valid=%b early_ready=%0d, required 4/1/0/0", tx_obs.size(), rx_ready, tx_valid, rr_bad);
    end
    while (tx_exp.size() > 0 && tx_obs.size() > 0) begin
      checks++;
      if (tx_obs[0] !== tx_exp[0]) begin
        errors++; $display("FAIL pull_byte: got %h required %h", tx_obs[0], tx_exp[0]);
      end
      void'(tx_obs.pop_front());
      void'(tx_exp.pop_front());
    end
    checks++;
    if (strobe_obs.size() != 1 || strobe_obs[0] !== strobe_exp[0]) begin
      errors++; $display("FAIL pull_strobe_log: got %0d strobes, required exactly %h", strobe_obs.size(), strobe_exp[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    strobe_exp.push_back({4'd2, 2'd0, 5'd7, 32'hCAFE_F00D});
    strobe_exp.push_back({4'd6, 2'd3, 5'd31, 32'h8001_7FFE});
    strobe_exp.push_back({4'd12, 2'd2, 5'd16, 32'h0000_0001});
    send_frame(8'hC2, 8'hE7, 32'hCAFE_F00D);
    send_frame(8'hF6, 8'h3F, 32'h8001_7FFE);
    send_frame(8'h2C, 8'h10, 32'h0000_0001);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobe_obs.size() != strobe_exp.size()) begin
      errors++; $display("FAIL b2b_count: got %0d strobes required %0d", strobe_obs.size(), strobe_exp.size());
    end else begin
      foreach (strobe_exp[k]) begin
        checks++;
        if (strobe_obs[k] !== strobe_exp[k]) begin
          errors++; $display("FAIL b2b_strobe: got %h required %h", strobe_obs[k], strobe_exp[k]);
        end
      end
    end
  endtask

  task automatic test_bad_actions();
    clear_q();
    send_frame(8'h00, 8'h01, 32'h1111_1111);
    @(posedge clk); #1;
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL nop_err: got %0d required 0", err_count);
    end
    for (int f = 1; f <= 256; f++) begin
      send_frame(8'h0E, 8'h02, 32'h0);
      if (f == 1 || f == 255 || f == 256) begin
        checks++;
        if (err_count !== ((f == 1) ? 8'd1 : 8'd255)) begin
          errors++; $display("FAIL bad_err_f%0d: got %0d required %0d", f, err_count, (f == 1) ? 1 : 255);
        end
      end
    end
    send_frame(8'hCD, 8'h00, 32'h0);
    send_frame(8'h3F, 8'h00, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (err_count !== 8'd255 || strobe_obs.size() != 0) begin
      errors++; $display("FAIL bad_saturate: err=%0d strobes=%0d required 255/0", err_count, strobe_obs.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_q();
    strobe_exp.push_back({4'd2, 2'd0, 5'd3, 32'h0000_0077});
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h34);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({rx_ready, err_count, din, action} !== 45'd0) begin
      errors++; $display("FAIL async_reset: rx_ready=%b err=%0d din=%h action=%0d required all 0", rx_ready, err_count, din, action);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_frame(8'h02, 8'h03, 32'h0000_0077);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobe_obs.size() != 1 || strobe_obs[0] !== strobe_exp[0]) begin
      errors++; $display("FAIL mid_reset_frame: got %0d strobes (first %h) required only %h", strobe_obs.size(), (strobe_obs.size() > 0) ? strobe_obs[0] : 43'd0, strobe_exp[0]);
    end
  endtask

`ifdef PIO_CMD_TIMEOUT_EN
  task automatic test_timeout();
    clear_q();
    strobe_exp.push_back({4'd4, 2'd0, 5'd9, 32'h1122_3344});
    send_byte(8'h01);
    send_byte(8'h05);
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'd0) begin
      errors++; $display("FAIL timeout_early: err=%0d required 0 after 15 idle cycles", err_count);
    end
    @(posedge clk); #1;
    checks++;
    if (err_count !== 8'd1 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL timeout_drop: err=%0d rx_ready=%b required 1/1", err_count, rx_ready);
    end
    send_frame(8'h04, 8'h09, 32'h1122_3344);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobe_obs.size() != 1 || strobe_obs[0] !== strobe_exp[0]) begin
      errors++; $display("FAIL timeout_next_hdr: got %0d strobes required only %h", strobe_obs.size(), strobe_exp[0]);
    end
  endtask
`else
  task automatic test_no_timeout();
    clear_q();
    strobe_exp.push_back({4'd4, 2'd0, 5'd9, 32'h1122_3344});
    send_byte(8'h04);
    send_byte(8'h09);
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'd0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL no_timeout_wait: err=%0d rx_ready=%b required 0/1", err_count, rx_ready);
    end
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobe_obs.size() != 1 || strobe_obs[0] !== strobe_exp[0]) begin
      errors++; $display("FAIL no_timeout_frame: got %0d strobes required only %h", strobe_obs.size(), strobe_exp[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_pull(1'b0);
    test_pull(1'b1);
    test_back_to_back();
    test_bad_actions();
    test_reset_mid_frame();
`ifdef PIO_CMD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
